// File: rtl/cgra_pkg.sv
// Shared CGRA handshake-node encodings: fork/branch and join/merge mode values.
package cgra_pkg;

  typedef enum logic [1:0] {
    FB_FORK      = 2'b00,
    FB_FORK_CTRL = 2'b01,
    FB_BRANCH    = 2'b10,
    FB_FORK_ALT  = 2'b11
  } fb_mode_e;

  typedef enum logic [1:0] {
    JM_JOIN      = 2'b00,
    JM_JOIN_CTRL = 2'b01,
    JM_MERGE     = 2'b10,
    JM_MERGE_ALT = 2'b11
  } jm_mode_e;

  localparam int TOK_CNT_WIDTH = 32;

endpackage

// File: rtl/fork_branch_ack.sv
// Per-output "already accepted the current token" flag of the eager fork.
module fork_branch_ack (
  input  logic clk,
  input  logic rst_n,
  input  logic hs,
  input  logic complete,
  input  logic clear,
  output logic done
);

  logic done_reg;
  logic done_next;

  // A completing token always wins over a same-cycle handshake.
  always_comb begin
    done_next = done_reg;
    if (clear || complete) begin
      done_next = 1'b0;
    end else if (hs) begin
      done_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= done_next;
    end
  end

  assign done = done_reg;

endmodule

// File: rtl/fork_branch.sv
// Eager fork / controlled fork / branch node for a CGRA token network.
// Optional feature: define FORK_BRANCH_TOKEN_CNT_EN to add the tok_cnt output.
module fork_branch
  import cgra_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_v,
  output logic                  din_r,
  input  logic                  cin,
  input  logic                  cin_v,
  output logic                  cin_r,
  output logic [DATA_WIDTH-1:0] dout_1,
  output logic                  dout_1_v,
  input  logic                  dout_1_r,
  output logic [DATA_WIDTH-1:0] dout_2,
  output logic                  dout_2_v,
  input  logic                  dout_2_r,
  input  logic [1:0]            mode
`ifdef FORK_BRANCH_TOKEN_CNT_EN
  ,
  output logic [TOK_CNT_WIDTH-1:0] tok_cnt
`endif
);

  fb_mode_e   mode_e;
  logic       is_branch;
  logic       is_ctrl;
  logic       tok_v;
  logic       rdy_all;
  logic       sel_r;
  logic       complete;
  logic [1:0] out_r;
  logic [1:0] out_v;
  logic [1:0] done;
  logic [1:0] hs;

  assign mode_e = fb_mode_e'(mode);
  assign dout_1 = din;
  assign dout_2 = din;

  // Readies are built from the partner's valid plus output readies and flags,
  // never from the stream's own valid.
  always_comb begin
    is_branch = (mode_e == FB_BRANCH);
    is_ctrl   = (mode_e == FB_FORK_CTRL);
    out_r     = {dout_2_r, dout_1_r};
    tok_v     = din_v & (is_ctrl ? cin_v : 1'b1);
    rdy_all   = (done[0] | out_r[0]) & (done[1] | out_r[1]);
    sel_r     = cin ? out_r[1] : out_r[0];
    if (is_branch) begin
      out_v = {din_v & cin_v & cin, din_v & cin_v & ~cin};
      din_r = cin_v & sel_r;
      cin_r = din_v & sel_r;
    end else begin
      out_v = {2{tok_v}} & ~done;
      din_r = (is_ctrl ? cin_v : 1'b1) & rdy_all;
      cin_r = is_ctrl & din_v & rdy_all;
    end
    hs       = out_v & out_r;
    complete = ~is_branch & tok_v & rdy_all;
  end

  assign dout_1_v = out_v[0];
  assign dout_2_v = out_v[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      fork_branch_ack u_ack (
        .clk      (clk),
        .rst_n    (rst_n),
        .hs       (hs[gi]),
        .complete (complete),
        .clear    (is_branch),
        .done     (done[gi])
      );
    end
  endgenerate

`ifdef FORK_BRANCH_TOKEN_CNT_EN
  logic [TOK_CNT_WIDTH-1:0] tok_cnt_reg;
  logic [TOK_CNT_WIDTH-1:0] tok_cnt_next;

  assign tok_cnt_next = (din_v & din_r) ? tok_cnt_reg + 1'b1 : tok_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_cnt_reg <= '0;
    end else begin
      tok_cnt_reg <= tok_cnt_next;
    end
  end

  assign tok_cnt = tok_cnt_reg;
`endif

endmodule

// File: tb/tb_fork_branch.sv
// Self-checking bench for fork_branch: token-level model plus directed vectors.
module tb_fork_branch;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          din_v, din_r;
  logic          cin, cin_v, cin_r;
  logic [DW-1:0] dout_1, dout_2;
  logic          dout_1_v, dout_1_r, dout_2_v, dout_2_r;
  logic [1:0]    mode;
`ifdef FORK_BRANCH_TOKEN_CNT_EN
  logic [31:0]   tok_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int hs1_cnt = 0;
  int hs2_cnt = 0;

  fork_branch #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_v    (din_v),
    .din_r    (din_r),
    .cin      (cin),
    .cin_v    (cin_v),
    .cin_r    (cin_r),
    .dout_1   (dout_1),
    .dout_1_v (dout_1_v),
    .dout_1_r (dout_1_r),
    .dout_2   (dout_2),
    .dout_2_v (dout_2_v),
    .dout_2_r (dout_2_r),
    .mode     (mode)
`ifdef FORK_BRANCH_TOKEN_CNT_EN
    ,
    .tok_cnt  (tok_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which outputs have already received the current fork token.
  bit got [2];

  always @(negedge clk) begin : compare
    bit tok, complete, sel;
    bit r [2];
    bit ev [2];
    bit hsm [2];
    bit exp_din_r, exp_cin_r;
    if (!rst_n) begin
      got[0] = 0;
      got[1] = 0;
    end
    r[0] = dout_1_r;
    r[1] = dout_2_r;
    if (mode == 2'b10) begin
      sel = cin;
      ev[0] = !sel && din_v && cin_v;
      ev[1] = sel && din_v && cin_v;
      exp_din_r = cin_v && r[sel];
      exp_cin_r = din_v && r[sel];
      hsm[0] = 0;
      hsm[1] = 0;
      complete = 0;
    end else begin
      tok = din_v && (mode != 2'b01 || cin_v);
      complete = tok;
      for (int k = 0; k < 2; k++) begin
        ev[k]  = tok && !got[k];
        hsm[k] = ev[k] && r[k];
        if (!(got[k] || hsm[k])) complete = 0;
      end
      exp_din_r = complete;
      exp_cin_r = (mode == 2'b01) ? complete : 0;
    end
    chk("dout_1_v", {31'd0, dout_1_v}, {31'd0, ev[0]});
    chk("dout_2_v", {31'd0, dout_2_v}, {31'd0, ev[1]});
    chk("dout_1", dout_1, din);
    chk("dout_2", dout_2, din);
    if (din_v) chk("din_r", {31'd0, din_r}, {31'd0, exp_din_r});
    if (cin_v || mode == 2'b00 || mode == 2'b11)
      chk("cin_r", {31'd0, cin_r}, {31'd0, exp_cin_r});
    hs1_cnt += int'(dout_1_v && dout_1_r);
    hs2_cnt += int'(dout_2_v && dout_2_r);
    if (!rst_n || mode == 2'b10 || complete) begin
      got[0] = 0;
      got[1] = 0;
    end else begin
      got[0] = got[0] || hsm[0];
      got[1] = got[1] || hsm[1];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic dv, input logic [31:0] d,
                       input logic cv, input logic c, input logic r1, input logic r2);
    mode = m; din_v = dv; din = d; cin_v = cv; cin = c; dout_1_r = r1; dout_2_r = r2;
  endtask

  // {mode[1:0], din_v, cin_v, cin, dout_1_r, dout_2_r}
  localparam logic [6:0] VEC [16] = '{
    7'b11_1_0_0_1_0, 7'b11_1_0_0_0_0, 7'b11_1_0_0_0_1, 7'b01_1_0_0_1_1,
    7'b01_1_1_0_0_1, 7'b01_1_1_0_1_0, 7'b01_0_1_0_1_1, 7'b10_1_1_0_1_1,
    7'b10_1_1_1_1_0, 7'b10_1_0_1_1_1, 7'b10_0_1_1_0_1, 7'b00_1_0_0_0_1,
    7'b10_1_1_0_0_0, 7'b00_1_0_0_1_1, 7'b00_0_0_0_1_1, 7'b00_1_0_1_1_1
  };

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_v1_idle", {31'd0, dout_1_v}, 32'd0);
    #1 din_v = 1'b1;
    @(negedge clk);
    chk("rst_v1_pass", {31'd0, dout_1_v}, 32'd1);
    chk("rst_v2_pass", {31'd0, dout_2_v}, 32'd1);
    next_cycle();
    rst_n = 1'b1;
    din_v = 1'b0;

    // Both outputs ready: zero-latency completion.
    next_cycle();
    drive(2'b00, 1'b1, 32'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t27_v1", {31'd0, dout_1_v}, 32'd1);
    chk("t27_v2", {31'd0, dout_2_v}, 32'd1);
    chk("t27_din_r", {31'd0, din_r}, 32'd1);
    chk("t27_dout", dout_1, 32'hA5);
    next_cycle();
    @(negedge clk);
    chk("t27_flags_clear", {30'd0, dout_2_v, dout_1_v}, 32'd3);

    // Output 2 stalls three cycles.
    next_cycle();
    hs1_cnt = 0;
    hs2_cnt = 0;
    drive(2'b00, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t28_c1_v1", {31'd0, dout_1_v}, 32'd1);
    chk("t28_c1_din_r", {31'd0, din_r}, 32'd0);
    for (int c = 2; c <= 3; c++) begin
      next_cycle();
      @(negedge clk);
      chk("t28_stall_v1", {31'd0, dout_1_v}, 32'd0);
      chk("t28_stall_v2", {31'd0, dout_2_v}, 32'd1);
      chk("t28_stall_din_r", {31'd0, din_r}, 32'd0);
    end
    next_cycle();
    dout_2_r = 1'b1;
    @(negedge clk);
    chk("t28_c4_din_r", {31'd0, din_r}, 32'd1);
    next_cycle();
    din_v = 1'b0;
    @(negedge clk);
    chk("t28_hs1_count", hs1_cnt, 32'd1);
    chk("t28_hs2_count", hs2_cnt, 32'd1);

    // Controlled fork waits for cin_v.
    next_cycle();
    drive(2'b01, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t29_v_gated", {30'd0, dout_2_v, dout_1_v}, 32'd0);
    next_cycle();
    cin_v = 1'b1;
    @(negedge clk);
    chk("t29_din_r", {31'd0, din_r}, 32'd1);
    chk("t29_cin_r", {31'd0, cin_r}, 32'd1);

    // Branch.
    next_cycle();
    drive(2'b10, 1'b1, 32'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t30_v", {30'd0, dout_2_v, dout_1_v}, 32'd2);
    chk("t30_rdy", {30'd0, cin_r, din_r}, 32'd3);
    chk("t30_dout2", dout_2, 32'h3C);
    next_cycle();
    cin = 1'b0;
    @(negedge clk);
    chk("t30_blocked_rdy", {30'd0, cin_r, din_r}, 32'd0);
    chk("t30_blocked_v", {30'd0, dout_2_v, dout_1_v}, 32'd1);

    // Reset mid-token discards partial delivery.
    next_cycle();
    drive(2'b00, 1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("t31_partial", {30'd0, dout_2_v, dout_1_v}, 32'd2);
    next_cycle();
    rst_n = 1'b0;
    dout_1_r = 1'b0;
    @(negedge clk);
    chk("t31_in_rst", {30'd0, dout_2_v, dout_1_v}, 32'd3);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t31_reoffer", {30'd0, dout_2_v, dout_1_v}, 32'd3);
    next_cycle();
    {dout_1_r, dout_2_r} = 2'b11;
    @(negedge clk);
    chk("t31_done", {31'd0, din_r}, 32'd1);

    // Entering branch mode clears a partial token.
    next_cycle();
    drive(2'b00, 1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    drive(2'b10, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(2'b00, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t20_cleared", {30'd0, dout_2_v, dout_1_v}, 32'd3);

    // Vector table, checked by the model each cycle.
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      drive(VEC[i][6:5], VEC[i][4], $urandom, VEC[i][3], VEC[i][2], VEC[i][1], VEC[i][0]);
    end
    next_cycle();
    drive(2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

`ifdef FORK_BRANCH_TOKEN_CNT_EN
    next_cycle();
    force dut.tok_cnt_reg = 32'hFFFF_FFFE;
    @(negedge clk);
    chk("t32_preload", tok_cnt, 32'hFFFF_FFFE);
    next_cycle();
    release dut.tok_cnt_reg;
    drive(2'b00, 1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("t32_cnt_ff", tok_cnt, 32'hFFFF_FFFF);
    next_cycle();
    din_v = 1'b0;
    @(negedge clk);
    chk("t32_wrap", tok_cnt, 32'h0000_0000);
`endif

    next_cycle();
    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
